// File: rtl/irq_controller.sv
// irq_controller: edge-triggered, maskable, fixed-priority interrupt controller
// for the single-cycle MIPS core. It sits in the peripheral bus window and
// tracks which source is in service until ERET.
module irq_controller #(
  parameter int          NSRC      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            kernel,
  input  logic            exc,
  input  logic            eret,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq,
  output logic [2:0]      irq_id
);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] src_event;
  logic [NSRC-1:0] pend_next;
  logic [NSRC-1:0] win_onehot;
  logic            gie;
  logic            insvc;
  logic            sel;
  logic            grant;
  logic [1:0]      word;
  logic [2:0]      win;
  logic            unused;

  // Only the upper bits of wdata beyond the register widths are ignored.
  assign unused = &{1'b0, wdata};

  // The window is four aligned words; misaligned byte addresses are not selected.
  assign sel  = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
  assign word = addr[3:2];

  assign src_event = src & ~src_q;
  assign req       = pend & mask;

  // The request is purely combinational so kernel/exc/mask changes act within the cycle.
  assign irq   = gie & (|req) & ~insvc & ~kernel & ~exc;
  assign grant = irq;

  // Lowest set index wins; scanning downwards leaves the lowest index last.
  always_comb begin
    win        = '0;
    win_onehot = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win           = 3'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Pending update: clears (W1C, grant) first, then new edges so a fresh event is never lost.
  always_comb begin
    pend_next = pend;
    if (wr && sel && (word == 2'd0)) begin
      pend_next = pend_next & ~wdata[NSRC-1:0];
    end
    if (grant) begin
      pend_next = pend_next & ~win_onehot;
    end
    pend_next = pend_next | src_event;
  end

  // Controller state: edge history, pending, mask, global enable and in-service tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q  <= '0;
      pend   <= '0;
      mask   <= '0;
      gie    <= 1'b0;
      insvc  <= 1'b0;
      irq_id <= '0;
    end else begin
      src_q <= src;
      pend  <= pend_next;
      if (wr && sel && (word == 2'd1)) begin
        mask <= wdata[NSRC-1:0];
      end
      if (wr && sel && (word == 2'd2)) begin
        gie <= wdata[0];
      end
      if (grant) begin
        insvc  <= 1'b1;
        irq_id <= win;
      end else if (eret) begin
        insvc <= 1'b0;
      end
    end
  end

  // Zero-latency read mux; drives 0 when not selected so it can be OR-combined on the bus.
  always_comb begin
    rdata = '0;
    if (rd && sel) begin
      case (word)
        2'd0:    rdata[NSRC-1:0] = pend;
        2'd1:    rdata[NSRC-1:0] = mask;
        2'd2:    rdata[0]        = gie;
        default: rdata[3:0]      = {insvc, irq_id};
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller: one task per scenario, inline checks.
`timescale 1ns/1ps
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h40000030;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src;
  logic        kernel, exc, eret, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        irq;
  logic [2:0]  irq_id;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] rv;

  irq_controller #(.NSRC(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .kernel(kernel), .exc(exc), .eret(eret),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq), .irq_id(irq_id)
  );

  // 40 ns clock; stimulus and sampling happen around the falling edge.
  always #20 clk = ~clk;

  task automatic do_write(input logic [3:0] off, input logic [31:0] data);
    @(negedge clk);
    wr = 1'b1; addr = BASE + {28'd0, off}; wdata = data;
    @(negedge clk);
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    #1;
    d = rdata;
    rd = 1'b0; addr = '0;
  endtask

  task automatic pulse_src(input logic [3:0] m);
    @(negedge clk); src = m;
    @(negedge clk); src = '0;
  endtask

  task automatic do_eret();
    @(negedge clk); eret = 1'b1;
    @(negedge clk); eret = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; src = '0; kernel = 1'b0; exc = 1'b0; eret = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; src = 4'h2; kernel = 1'b0; exc = 1'b0; eret = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    @(negedge clk); @(negedge clk);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_irq: got %b need 0", irq); end
    vectors++; if (irq_id !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_id: got %0d need 0", irq_id); end
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pend: got %h need 0", rv); end
    do_read(BASE + 32'hC, rv);
    vectors++; if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_stat: got %h need 0", rv); end
    reset = 1'b1;
    @(negedge clk);
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h2) begin miscompares++; $display("[TB] FAIL release_event: got %h need 2", rv); end
    src = '0;
    @(negedge clk);
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h2) begin miscompares++; $display("[TB] FAIL release_single: got %h need 2", rv); end
  endtask

  task automatic test_basic_grant();
    apply_reset();
    do_write(4'h4, 32'h3);
    do_write(4'h8, 32'h1);
    pulse_src(4'h2);
    #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_irq: got %b need 1", irq); end
    @(negedge clk);
    vectors++; if (irq_id !== 3'd1) begin miscompares++; $display("[TB] FAIL basic_id: got %0d need 1", irq_id); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_irq_svc: got %b need 0", irq); end
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL basic_pend: got %h need 0", rv); end
    do_read(BASE + 32'hC, rv);
    vectors++; if (rv !== 32'h9) begin miscompares++; $display("[TB] FAIL basic_stat: got %h need 9", rv); end
    do_eret();
    do_read(BASE + 32'hC, rv);
    vectors++; if (rv !== 32'h1) begin miscompares++; $display("[TB] FAIL basic_stat_eret: got %h need 1", rv); end
  endtask

  task automatic test_priority();
    apply_reset();
    do_write(4'h4, 32'hF);
    do_write(4'h8, 32'h1);
    pulse_src(4'h5);
    #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL prio_irq: got %b need 1", irq); end
    @(negedge clk);
    vectors++; if (irq_id !== 3'd0) begin miscompares++; $display("[TB] FAIL prio_first: got %0d need 0", irq_id); end
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h4) begin miscompares++; $display("[TB] FAIL prio_pend: got %h need 4", rv); end
    @(negedge clk); eret = 1'b1;
    #1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL prio_eret_cycle: got %b need 0", irq); end
    @(negedge clk); eret = 1'b0;
    #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL prio_reassert: got %b need 1", irq); end
    @(negedge clk);
    vectors++; if (irq_id !== 3'd2) begin miscompares++; $display("[TB] FAIL prio_second: got %0d need 2", irq_id); end
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL prio_pend_empty: got %h need 0", rv); end
  endtask

  task automatic test_w1c_collision();
    apply_reset();
    pulse_src(4'h8);
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h8) begin miscompares++; $display("[TB] FAIL w1c_setup: got %h need 8", rv); end
    @(negedge clk);
    src = 4'h8; wr = 1'b1; addr = BASE; wdata = 32'h8;
    @(negedge clk);
    src = '0; wr = 1'b0; addr = '0; wdata = '0;
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h8) begin miscompares++; $display("[TB] FAIL w1c_set_wins: got %h need 8", rv); end
    do_write(4'h0, 32'h8);
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL w1c_clear: got %h need 0", rv); end
  endtask

  task automatic test_grant_collision();
    apply_reset();
    kernel = 1'b1;
    do_write(4'h4, 32'h1);
    do_write(4'h8, 32'h1);
    pulse_src(4'h1);
    #1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL kernel_block: got %b need 0", irq); end
    @(negedge clk);
    kernel = 1'b0; src = 4'h1;
    #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL kernel_drop: got %b need 1", irq); end
    @(negedge clk);
    src = '0;
    vectors++; if (irq_id !== 3'd0) begin miscompares++; $display("[TB] FAIL coll_id: got %0d need 0", irq_id); end
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h1) begin miscompares++; $display("[TB] FAIL coll_pend_kept: got %h need 1", rv); end
    do_eret();
    #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL coll_after_eret: got %b need 1", irq); end
  endtask

  task automatic test_kernel_exc();
    apply_reset();
    kernel = 1'b1;
    do_write(4'h4, 32'h1);
    do_write(4'h8, 32'h1);
    pulse_src(4'h1);
    @(negedge clk);
    kernel = 1'b0; exc = 1'b1;
    #1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL exc_block: got %b need 0", irq); end
    @(negedge clk);
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h1) begin miscompares++; $display("[TB] FAIL exc_pend: got %h need 1", rv); end
    do_read(BASE + 32'hC, rv);
    vectors++; if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL exc_no_grant: got %h need 0", rv); end
    do_write(4'h4, 32'h0);
    exc = 1'b0;
    #1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_drop: got %b need 0", irq); end
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h1) begin miscompares++; $display("[TB] FAIL mask_pend_kept: got %h need 1", rv); end
    do_write(4'h4, 32'h1);
    #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL unmask_irq: got %b need 1", irq); end
    @(negedge clk);
    do_read(BASE + 32'hC, rv);
    vectors++; if (rv !== 32'h8) begin miscompares++; $display("[TB] FAIL unmask_grant: got %h need 8", rv); end
  endtask

  task automatic test_bus();
    apply_reset();
    do_write(4'h4, 32'h5);
    do_read(BASE + 32'h4, rv);
    vectors++; if (rv !== 32'h5) begin miscompares++; $display("[TB] FAIL bus_mask: got %h need 5", rv); end
    do_read(32'h40000010, rv);
    vectors++; if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL bus_unsel: got %h need 0", rv); end
    addr = BASE + 32'h4;
    #1;
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL bus_no_rd: got %h need 0", rdata); end
    addr = '0;
    do_write(4'h8, 32'hFFFFFFFF);
    do_read(BASE + 32'h8, rv);
    vectors++; if (rv !== 32'h1) begin miscompares++; $display("[TB] FAIL bus_ctrl: got %h need 1", rv); end
    do_write(4'hC, 32'hFF);
    do_read(BASE + 32'hC, rv);
    vectors++; if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL bus_stat_ro: got %h need 0", rv); end
  endtask

  task automatic test_reset_in_service();
    apply_reset();
    do_write(4'h4, 32'hF);
    do_write(4'h8, 32'h1);
    pulse_src(4'h1);
    @(negedge clk);
    pulse_src(4'h6);
    do_read(BASE + 32'h0, rv);
    vectors++; if (rv !== 32'h6) begin miscompares++; $display("[TB] FAIL svc_pend: got %h need 6", rv); end
    do_read(BASE + 32'hC, rv);
    vectors++; if (rv !== 32'h8) begin miscompares++; $display("[TB] FAIL svc_stat: got %h need 8", rv); end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL async_irq: got %b need 0", irq); end
    vectors++; if (irq_id !== 3'd0) begin miscompares++; $display("[TB] FAIL async_id: got %0d need 0", irq_id); end
    for (int k = 0; k < 4; k++) begin
      do_read(BASE + 32'(4 * k), rv);
      vectors++; if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL async_reg%0d: got %h need 0", k, rv); end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_priority();
    test_w1c_collision();
    test_grant_collision();
    test_kernel_exc();
    test_bus();
    test_reset_in_service();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
